// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared constants and types for the 5-stage RISC-V pipeline
//                (machine width, bubble encoding, base opcodes, fetch state).
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Machine width and the canonical bubble (addi x0,x0,0)
    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Base opcodes shared with the ID-stage decoder
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Fetch-unit control state
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Loads a fetched instruction with its
//                PC and PC+4, holds on stall, and inserts a bubble when flushed
//                or when nothing new is available.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [31:0]     load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    // Priority: flush > load > hold (stall) > bubble; PC fields keep their
    // last value whenever a bubble is inserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
            pc4   <= load_pc + XLEN'(4);
        end else if (!stall) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Owns the PC, keeps at most one
//                instruction-memory read in flight, parks one returned word in
//                a single-entry buffer while IF/ID is stalled, and honours EX
//                redirects and the decoder's HALT.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage
    import riscv_pkg::fetch_state_t;
    import riscv_pkg::RUN;
    import riscv_pkg::HALTED;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            if_id_valid_o,
    output logic [31:0]     if_id_inst_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic            halted_o
);

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc;
    logic            pending;
    logic            drop;

    logic            buf_valid;
    logic [31:0]     buf_inst;
    logic [XLEN-1:0] buf_pc;

    logic            running;
    logic            resp;
    logic            redirect_acc;
    logic            halt_acc;
    logic            issue;
    logic            resp_keep;
    logic            ifid_load;
    logic            ifid_flush;
    logic [31:0]     ifid_load_inst;
    logic [XLEN-1:0] ifid_load_pc;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign running      = (state == RUN);
    assign resp         = imem_rvalid_i && pending;
    // Redirects are ignored once fetch has stopped.
    assign redirect_acc = redirect_i && running;
    assign halt_acc     = halt_i && if_id_valid_o && !stall_i && !redirect_i && running;

    // A new read may go out when nothing is in flight, or when the word in
    // flight is returning this cycle and can be consumed directly.
    assign issue = rst_n && running && !redirect_i && !buf_valid &&
                   (!pending || (imem_rvalid_i && !stall_i));

    // A returning word is kept only if it is not stale and this cycle does
    // not flush the front end.
    assign resp_keep = resp && !drop && !redirect_acc && !halt_acc;

    assign ifid_flush     = redirect_acc || halt_acc;
    assign ifid_load      = !stall_i && (resp_keep || buf_valid);
    assign ifid_load_inst = resp_keep ? imem_rdata_i : buf_inst;
    assign ifid_load_pc   = resp_keep ? req_pc       : buf_pc;

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_q;
    assign halted_o    = (state == HALTED);

    // ------------------------------------------------------------------
    // Fetch state register
    // ------------------------------------------------------------------
    // Holds RUN/HALTED; HALTED is only left through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: an accepted halt stops fetch permanently.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_acc) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // PC, outstanding-request tracking and stale-response squashing
    // ------------------------------------------------------------------
    // pc_q advances on every issue (wrapping at 2^XLEN) and jumps on redirect;
    // drop marks an in-flight word that belongs to a discarded path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            req_pc  <= '0;
            pending <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (redirect_acc) begin
                pc_q <= redirect_pc_i;
            end else if (issue) begin
                pc_q   <= pc_q + XLEN'(4);
                req_pc <= pc_q;
            end

            if (issue) begin
                pending <= 1'b1;
            end else if (resp) begin
                pending <= 1'b0;
            end

            if (halt_acc) begin
                drop <= 1'b1;
            end else if (redirect_acc) begin
                drop <= pending && !imem_rvalid_i;
            end else if (resp) begin
                drop <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-entry skid buffer
    // ------------------------------------------------------------------
    // Captures a returning word while IF/ID is stalled and drains into IF/ID
    // on the first unstalled cycle; a flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_inst  <= NOP_INST;
            buf_pc    <= '0;
        end else if (ifid_flush) begin
            buf_valid <= 1'b0;
        end else if (resp_keep && stall_i) begin
            buf_valid <= 1'b1;
            buf_inst  <= imem_rdata_i;
            buf_pc    <= req_pc;
        end else if (!stall_i) begin
            buf_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifid_load),
        .load_inst (ifid_load_inst),
        .load_pc   (ifid_load_pc),
        .stall     (stall_i),
        .flush     (ifid_flush),
        .valid     (if_id_valid_o),
        .inst      (if_id_inst_o),
        .pc        (if_id_pc_o),
        .pc4       (if_id_pc4_o)
    );

endmodule : if_stage
`default_nettype wire
